// File: rtl/md_pkg.sv
// md_pkg: shared types and decode helpers for the multiply/divide issue block.
//   md_op_t  - EX-stage HI/LO-class opcode (4 bits)
//   state_t  - issue FSM states
//   is_md / is_sgn / is_div - opcode classification helpers
package md_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    // Operation needs the multi-cycle engine
    function automatic logic is_md(md_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_sgn(md_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div(md_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_issue_ctrl_hilo_regs.sv
// hilo_regs: architectural HI/LO register pair.
//   i_commit       - load pending engine result into both HI and LO
//   i_pend_hi/lo   - staged result
//   i_mthi/i_mtlo  - move-to write enables, data on i_wdata
//   o_hi/o_lo      - architectural values
// Commit and MT writes are mutually exclusive by construction of the FSM
// (commit only from DONE, MT only from IDLE); commit is still given priority.
module hilo_regs #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_commit,
    input  logic [DW-1:0] i_pend_hi,
    input  logic [DW-1:0] i_pend_lo,
    input  logic          i_mthi,
    input  logic          i_mtlo,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_hi,
    output logic [DW-1:0] o_lo
);

    logic [DW-1:0] r_hi;
    logic [DW-1:0] r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_commit) begin
            r_hi <= i_pend_hi;
            r_lo <= i_pend_lo;
        end else begin
            if (i_mthi) r_hi <= i_wdata;
            if (i_mtlo) r_lo <= i_wdata;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: EX-stage initiator for the multi-cycle multiply/divide engine.
// Decodes HI/LO-class ops, issues operands over req/ack/done, stalls IF..EX
// while the engine works, stages the result until commit, and owns HI/LO.
//   ex_*        - EX instruction (valid, opcode, rs, rt)
//   flush       - exception flush of the EX instruction
//   mem_stall   - downstream stall, EX instruction held
//   pipe_stall  - freeze IF..EX
//   mf_result   - HI for MFHI, LO for MFLO, else 0
//   hi/lo       - architectural HI/LO
//   eng_*       - engine handshake (req/ack/done, kill pulse, operands, result)
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [3:0]    ex_op,
    input  logic [DW-1:0] ex_rs,
    input  logic [DW-1:0] ex_rt,
    input  logic          flush,
    input  logic          mem_stall,
    output logic          pipe_stall,
    output logic [DW-1:0] mf_result,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo,
    output logic          eng_req,
    output logic          eng_sgn,
    output logic          eng_div,
    output logic [DW-1:0] eng_a,
    output logic [DW-1:0] eng_b,
    output logic          eng_kill,
    input  logic          eng_ack,
    input  logic          eng_done,
    input  logic [DW-1:0] eng_hi,
    input  logic [DW-1:0] eng_lo
);

    state_t        r_state, w_next;
    md_op_t        w_op;
    logic          w_md_go, w_div0;
    logic          w_commit, w_abort, w_mthi, w_mtlo;
    logic          r_kill, r_sgn, r_div;
    logic [DW-1:0] r_a, r_b, r_pend_hi, r_pend_lo;

    assign w_op    = md_op_t'(ex_op);
    assign w_md_go = ex_valid & is_md(w_op) & ~flush;
    // Divide by zero never reaches the engine: HI/LO are re-committed unchanged
    assign w_div0  = is_div(w_op) & (ex_rt == '0);

    always_comb begin
        w_next     = r_state;
        pipe_stall = 1'b0;
        eng_req    = 1'b0;
        w_commit   = 1'b0;
        w_abort    = 1'b0;
        w_mthi     = 1'b0;
        w_mtlo     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_md_go) begin
                    // The divide-by-zero shortcut completes without freezing the pipe
                    pipe_stall = ~w_div0;
                    w_next     = w_div0 ? DONE : REQ;
                end else if (ex_valid & ~flush & ~mem_stall) begin
                    w_mthi = (w_op == OP_MTHI);
                    w_mtlo = (w_op == OP_MTLO);
                end
            end
            REQ: begin
                if (flush) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end else begin
                    eng_req    = 1'b1;
                    pipe_stall = 1'b1;
                    if (eng_ack) w_next = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end else begin
                    pipe_stall = 1'b1;
                    if (eng_done) w_next = DONE;
                end
            end
            DONE: begin
                if (flush) begin
                    w_next = IDLE;
                end else if (~mem_stall) begin
                    w_commit = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_kill    <= 1'b0;
            r_sgn     <= 1'b0;
            r_div     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else begin
            r_state <= w_next;
            // Kill is the registered image of an abort, so it is exactly one cycle
            r_kill  <= w_abort;
            if (r_state == IDLE && w_md_go) begin
                r_a   <= ex_rs;
                r_b   <= ex_rt;
                r_sgn <= is_sgn(w_op);
                r_div <= is_div(w_op);
                if (w_div0) begin
                    r_pend_hi <= hi;
                    r_pend_lo <= lo;
                end
            end
            if (r_state == BUSY && ~flush && eng_done) begin
                r_pend_hi <= eng_hi;
                r_pend_lo <= eng_lo;
            end
        end
    end

    hilo_regs #(.DW(DW)) u_hilo (
        .clk       (clk),
        .rst       (rst),
        .i_commit  (w_commit),
        .i_pend_hi (r_pend_hi),
        .i_pend_lo (r_pend_lo),
        .i_mthi    (w_mthi),
        .i_mtlo    (w_mtlo),
        .i_wdata   (ex_rs),
        .o_hi      (hi),
        .o_lo      (lo)
    );

    assign mf_result = (w_op == OP_MFHI) ? hi :
                       (w_op == OP_MFLO) ? lo : '0;
    assign eng_kill  = r_kill;
    assign eng_sgn   = r_sgn;
    assign eng_div   = r_div;
    assign eng_a     = r_a;
    assign eng_b     = r_b;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: table of single-cycle MT/MF vectors, then
// hand-written multi-cycle sequences acting as the engine.
module tb_md_issue_ctrl;
    import md_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ex_valid = 1'b0;
    logic [3:0]    ex_op = 4'd0;
    logic [DW-1:0] ex_rs = '0, ex_rt = '0;
    logic          flush = 1'b0, mem_stall = 1'b0;
    logic          pipe_stall;
    logic [DW-1:0] mf_result, hi, lo;
    logic          eng_req, eng_sgn, eng_div, eng_kill;
    logic [DW-1:0] eng_a, eng_b;
    logic          eng_ack = 1'b0, eng_done = 1'b0;
    logic [DW-1:0] eng_hi = '0, eng_lo = '0;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int stall_cnt = 0;
    logic req_q = 1'b0;

    always #5 clk = ~clk;

    md_issue_ctrl #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .mem_stall(mem_stall),
        .pipe_stall(pipe_stall), .mf_result(mf_result), .hi(hi), .lo(lo),
        .eng_req(eng_req), .eng_sgn(eng_sgn), .eng_div(eng_div),
        .eng_a(eng_a), .eng_b(eng_b), .eng_kill(eng_kill),
        .eng_ack(eng_ack), .eng_done(eng_done), .eng_hi(eng_hi), .eng_lo(eng_lo)
    );

    // Count request rising edges and stalled cycles
    always @(negedge clk) begin
        if (eng_req && !req_q) req_cnt <= req_cnt + 1;
        if (pipe_stall) stall_cnt <= stall_cnt + 1;
        req_q <= eng_req;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input md_op_t op, input logic [DW-1:0] rs, input logic [DW-1:0] rt);
        ex_valid = v;
        ex_op    = op;
        ex_rs    = rs;
        ex_rt    = rt;
    endtask

    typedef struct {
        logic          v;
        md_op_t        op;
        logic [DW-1:0] rs;
        logic          fl;
        logic          ms;
        logic [DW-1:0] e_mf;
        logic [DW-1:0] e_hi;
        logic [DW-1:0] e_lo;
    } vec_t;

    vec_t tv[11];
    int   rc0;
    int   sc0;

    initial begin
        tv[0]  = '{1'b1, OP_MTHI, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 32'h0};
        tv[1]  = '{1'b1, OP_MFHI, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        tv[2]  = '{1'b1, OP_MTLO, 32'h12345678, 1'b0, 1'b1, 32'h0,        32'hDEADBEEF, 32'h0};
        tv[3]  = '{1'b1, OP_MFLO, 32'h0,        1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 32'h0};
        tv[4]  = '{1'b1, OP_MTLO, 32'h12345678, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678};
        tv[5]  = '{1'b1, OP_MFLO, 32'h0,        1'b0, 1'b0, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
        tv[6]  = '{1'b1, OP_MTHI, 32'h1,        1'b1, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678};
        tv[7]  = '{1'b0, OP_MTHI, 32'h55,       1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678};
        tv[8]  = '{1'b1, OP_NONE, 32'h77,       1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678};
        tv[9]  = '{1'b1, OP_MTHI, 32'h11,       1'b0, 1'b0, 32'h0,        32'h11,       32'h12345678};
        tv[10] = '{1'b1, OP_MTLO, 32'h22,       1'b0, 1'b0, 32'h0,        32'h11,       32'h22};

        // ---------------- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_req", {31'b0, eng_req}, 0);
        chk("rst_kill", {31'b0, eng_kill}, 0);
        chk("rst_sgn_div", {30'b0, eng_sgn, eng_div}, 0);
        chk("rst_a", eng_a, 0);
        chk("rst_b", eng_b, 0);
        chk("rst_stall", {31'b0, pipe_stall}, 0);
        rst = 1'b0;
        tick();

        // ---------------- table: MT/MF single-cycle ops
        for (int i = 0; i < 11; i++) begin
            drive(tv[i].v, tv[i].op, tv[i].rs, 32'h0);
            flush     = tv[i].fl;
            mem_stall = tv[i].ms;
            settle();
            chk($sformatf("tv%0d_mf", i), mf_result, tv[i].e_mf);
            chk($sformatf("tv%0d_stall", i), {31'b0, pipe_stall}, 0);
            tick();
            chk($sformatf("tv%0d_hi", i), hi, tv[i].e_hi);
            chk($sformatf("tv%0d_lo", i), lo, tv[i].e_lo);
        end
        drive(1'b0, OP_NONE, 0, 0);
        flush = 1'b0;
        mem_stall = 1'b0;
        tick();

        // ---------------- MULT -3 * 5: ack after 1 cycle, done after 4 BUSY cycles
        drive(1'b1, OP_MULT, 32'hFFFFFFFD, 32'h5);
        settle();
        chk("mult_idle_stall", {31'b0, pipe_stall}, 1);
        chk("mult_idle_req", {31'b0, eng_req}, 0);
        tick();
        settle();
        chk("mult_req", {31'b0, eng_req}, 1);
        chk("mult_req_stall", {31'b0, pipe_stall}, 1);
        chk("mult_sgn", {31'b0, eng_sgn}, 1);
        chk("mult_div", {31'b0, eng_div}, 0);
        chk("mult_a", eng_a, 32'hFFFFFFFD);
        chk("mult_b", eng_b, 32'h5);
        eng_ack = 1'b1;
        tick();
        eng_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("mult_busy%0d_stall", i), {31'b0, pipe_stall}, 1);
            chk($sformatf("mult_busy%0d_req", i), {31'b0, eng_req}, 0);
            tick();
        end
        eng_done = 1'b1;
        eng_hi   = 32'hFFFFFFFF;
        eng_lo   = 32'hFFFFFFF1;
        settle();
        chk("mult_done_cyc_stall", {31'b0, pipe_stall}, 1);
        tick();
        eng_done = 1'b0;
        settle();
        chk("mult_DONE_stall", {31'b0, pipe_stall}, 0);
        chk("mult_DONE_hi_old", hi, 32'h11);
        tick();
        drive(1'b0, OP_NONE, 0, 0);
        settle();
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);
        chk("mult_post_stall", {31'b0, pipe_stall}, 0);
        tick();

        // ---------------- DIV 7 / -2 with mem_stall held 3 cycles in DONE
        rc0 = req_cnt;
        drive(1'b1, OP_DIV, 32'h7, 32'hFFFFFFFE);
        settle();
        chk("div_idle_stall", {31'b0, pipe_stall}, 1);
        tick();
        eng_ack = 1'b1;
        settle();
        chk("div_req", {31'b0, eng_req}, 1);
        chk("div_sgn_div", {30'b0, eng_sgn, eng_div}, 2'b11);
        tick();
        eng_ack  = 1'b0;
        eng_done = 1'b1;
        eng_hi   = 32'h00000001;
        eng_lo   = 32'hFFFFFFFD;
        tick();
        eng_done  = 1'b0;
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("div_ms%0d_stall", i), {31'b0, pipe_stall}, 0);
            chk($sformatf("div_ms%0d_req", i), {31'b0, eng_req}, 0);
            tick();
            chk($sformatf("div_ms%0d_hi", i), hi, 32'hFFFFFFFF);
        end
        mem_stall = 1'b0;
        tick();
        drive(1'b0, OP_NONE, 0, 0);
        settle();
        chk("div_hi", hi, 32'h00000001);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_one_req", req_cnt - rc0, 1);
        tick();

        // ---------------- DIVU by zero: HI/LO unchanged, no request, no stall
        drive(1'b1, OP_MTHI, 32'h11, 0);
        tick();
        drive(1'b1, OP_MTLO, 32'h22, 0);
        tick();
        drive(1'b0, OP_NONE, 0, 0);
        tick();
        rc0 = req_cnt;
        sc0 = stall_cnt;
        drive(1'b1, OP_DIVU, 32'h9, 32'h0);
        settle();
        chk("div0_idle_stall", {31'b0, pipe_stall}, 0);
        tick();
        drive(1'b0, OP_NONE, 0, 0);
        settle();
        chk("div0_done_stall", {31'b0, pipe_stall}, 0);
        chk("div0_done_req", {31'b0, eng_req}, 0);
        chk("div0_sgn_div", {30'b0, eng_sgn, eng_div}, 2'b01);
        tick();
        settle();
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);
        chk("div0_no_req", req_cnt - rc0, 0);
        chk("div0_no_stall", stall_cnt - sc0, 0);
        tick();

        // ---------------- MULTU flushed 2 cycles into BUSY
        drive(1'b1, OP_MULTU, 32'h3, 32'h4);
        tick();
        eng_ack = 1'b1;
        settle();
        chk("fl_sgn", {31'b0, eng_sgn}, 0);
        tick();
        eng_ack = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        settle();
        chk("fl_flushcyc_stall", {31'b0, pipe_stall}, 0);
        chk("fl_flushcyc_kill", {31'b0, eng_kill}, 0);
        tick();
        flush = 1'b0;
        drive(1'b0, OP_NONE, 0, 0);
        eng_done = 1'b1;
        eng_hi   = 32'hAAAAAAAA;
        eng_lo   = 32'hBBBBBBBB;
        settle();
        chk("fl_kill", {31'b0, eng_kill}, 1);
        chk("fl_req", {31'b0, eng_req}, 0);
        chk("fl_stall", {31'b0, pipe_stall}, 0);
        tick();
        eng_done = 1'b0;
        settle();
        chk("fl_kill_once", {31'b0, eng_kill}, 0);
        chk("fl_hi", hi, 32'h11);
        tick();
        settle();
        chk("fl_hi_late", hi, 32'h11);
        chk("fl_lo_late", lo, 32'h22);
        chk("fl_stall_late", {31'b0, pipe_stall}, 0);
        tick();

        // ---------------- reset while BUSY
        drive(1'b1, OP_MULT, 32'h2, 32'h3);
        tick();
        eng_ack = 1'b1;
        tick();
        eng_ack = 1'b0;
        drive(1'b0, OP_NONE, 0, 0);
        settle();
        chk("rb_busy_stall", {31'b0, pipe_stall}, 1);
        rst = 1'b1;
        tick();
        settle();
        chk("rb_stall", {31'b0, pipe_stall}, 0);
        chk("rb_req", {31'b0, eng_req}, 0);
        chk("rb_hi", hi, 0);
        chk("rb_lo", lo, 0);
        chk("rb_a", eng_a, 0);
        rst = 1'b0;
        tick();
        settle();
        chk("rb_idle_stall", {31'b0, pipe_stall}, 0);
        chk("rb_idle_req", {31'b0, eng_req}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
